// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-cycle sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef logic [3:0] bcd_t;

  // Largest digit allowed in the seconds-tens position.
  localparam bcd_t MAX_SEC_TENS = 4'd5;
  localparam bcd_t MAX_BCD      = 4'd9;

  localparam int QUICK_SECS_TENS_DEFAULT = 3;
  localparam int BEEP_SECS_DEFAULT       = 3;

  // A key may shift in only if it is a decimal digit and the digit it pushes
  // into the seconds-tens slot is a legal tens value.
  function automatic logic key_ok(input bcd_t digit, input bcd_t cur_ones);
    return (digit <= MAX_BCD) && (cur_ones <= MAX_SEC_TENS);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// MM:SS keypad entry register: shifts accepted digits in from the right,
// rejects non-decimal keys and keys that would make the seconds-tens digit
// exceed 5, and reports whether the shifted value would be nonzero.
module bcd_entry_reg
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       zero,
  input  logic       quick,
  input  logic       shift,
  input  logic [3:0] digit,
  input  logic [3:0] quick_tens,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       accept,
  output logic       shift_nonzero
);

  // Accept decision and zero detect of the would-be shifted entry.
  always_comb begin
    accept        = key_ok(digit, sec_ones);
    shift_nonzero = (sec_tens != 4'd0) || (sec_ones != 4'd0) || (digit != 4'd0);
  end

  // Entry digits: zeroing beats the quick preset, which beats a key shift.
  always_ff @(posedge clk) begin
    if (rst || zero) begin
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (quick) begin
      mins     <= 4'd0;
      sec_tens <= quick_tens;
      sec_ones <= 4'd0;
    end else if (shift && accept) begin
      mins     <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end
  end

endmodule

// File: rtl/microwave_sequencer.sv
// Cook-cycle controller: keypad entry, timer load/count/clear sequencing,
// magnetron gating and end-of-cook beeper.
// Optional feature macro: MICROWAVE_QUICK_START_EN (start in IDLE loads
// 0:QUICK_SECS_TENS0 and cooks; start in COOK pulses add30).
// Inputs are one-cycle pulses except door_closed (level); priority within a
// cycle is clear > stop > door open > start > key_valid. All outputs are
// registered from the next state, so they change on the edge that takes the
// transition.
module microwave_sequencer
  import microwave_pkg::*;
#(
  parameter int BEEP_SECS       = BEEP_SECS_DEFAULT,
  parameter int QUICK_SECS_TENS = QUICK_SECS_TENS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       tick_1hz,
  input  logic       timer_zero,
  output logic       timer_load,
  output logic       timer_en,
  output logic       timer_clr,
  output logic [3:0] load_mins,
  output logic [3:0] load_sec_tens,
  output logic [3:0] load_sec_ones,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] fsm_state
`ifdef MICROWAVE_QUICK_START_EN
  ,
  output logic       add30
`endif
);

  state_t     state, next_state;
  logic [3:0] beep_cnt, cnt_next;
  logic       entry_zero, entry_quick, entry_shift;
  logic       entry_accept, entry_shift_nonzero;
  logic       clr_next;
`ifdef MICROWAVE_QUICK_START_EN
  logic       add30_next;
`endif

  bcd_entry_reg u_entry (
    .clk          (clk),
    .rst          (rst),
    .zero         (entry_zero),
    .quick        (entry_quick),
    .shift        (entry_shift),
    .digit        (key_digit),
    .quick_tens   (4'(QUICK_SECS_TENS)),
    .mins         (load_mins),
    .sec_tens     (load_sec_tens),
    .sec_ones     (load_sec_ones),
    .accept       (entry_accept),
    .shift_nonzero(entry_shift_nonzero)
  );

  // Next-state, entry control and strobe decode.
  always_comb begin
    next_state  = state;
    entry_zero  = 1'b0;
    entry_quick = 1'b0;
    entry_shift = 1'b0;
    clr_next    = 1'b0;
    cnt_next    = beep_cnt;
`ifdef MICROWAVE_QUICK_START_EN
    add30_next  = 1'b0;
`endif
    if (clear) begin
      next_state = S_IDLE;
      entry_zero = 1'b1;
      clr_next   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_SET: begin
          if (!stop) begin
            if (start && door_closed && (state == S_SET)) begin
              next_state = S_LOAD;
`ifdef MICROWAVE_QUICK_START_EN
            end else if (start && door_closed && (state == S_IDLE)) begin
              entry_quick = 1'b1;
              next_state  = S_LOAD;
`endif
            end else if (key_valid) begin
              entry_shift = 1'b1;
              if (entry_accept)
                next_state = entry_shift_nonzero ? S_SET : S_IDLE;
            end
          end
        end
        S_LOAD: next_state = S_COOK;
        S_COOK: begin
          if (stop || !door_closed) begin
            next_state = S_PAUSE;
          end else if (timer_zero) begin
            next_state = S_DONE;
`ifdef MICROWAVE_QUICK_START_EN
          end else if (start) begin
            add30_next = 1'b1;
`endif
          end
        end
        S_PAUSE: begin
          if (stop) begin
            next_state = S_IDLE;
            entry_zero = 1'b1;
            clr_next   = 1'b1;
          end else if (start && door_closed) begin
            next_state = S_COOK;
          end
        end
        S_DONE: begin
          if (stop) begin
            next_state = S_IDLE;
            entry_zero = 1'b1;
          end else if (tick_1hz) begin
            if (beep_cnt == 4'(BEEP_SECS - 1)) begin
              next_state = S_IDLE;
              entry_zero = 1'b1;
            end else begin
              cnt_next = beep_cnt + 4'd1;
            end
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
    if (next_state != S_DONE) cnt_next = 4'd0;
  end

  // State, beep counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beep_cnt   <= 4'd0;
      timer_load <= 1'b0;
      timer_en   <= 1'b0;
      timer_clr  <= 1'b0;
      mag_on     <= 1'b0;
      beep       <= 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
      add30      <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      beep_cnt   <= cnt_next;
      timer_load <= (next_state == S_LOAD);
      timer_en   <= (next_state == S_COOK);
      mag_on     <= (next_state == S_COOK);
      beep       <= (next_state == S_DONE);
      timer_clr  <= clr_next;
`ifdef MICROWAVE_QUICK_START_EN
      add30      <= add30_next;
`endif
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Self-checking bench for microwave_sequencer: directed scenarios plus
// randomized keypad entry and cook cycles against a digit-level entry model.
module tb_microwave_sequencer;
  import microwave_pkg::*;

  localparam int BEEP = 3;

  logic       clk = 1'b0;
  logic       rst, key_valid, start, stop, clear, door_closed, tick_1hz, timer_zero;
  logic [3:0] key_digit;
  logic       timer_load, timer_en, timer_clr, mag_on, beep;
  logic [3:0] load_mins, load_sec_tens, load_sec_ones;
  logic [2:0] fsm_state;
`ifdef MICROWAVE_QUICK_START_EN
  logic       add30;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] model_entry;

  microwave_sequencer #(.BEEP_SECS(BEEP), .QUICK_SECS_TENS(3)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .tick_1hz(tick_1hz), .timer_zero(timer_zero), .timer_load(timer_load),
    .timer_en(timer_en), .timer_clr(timer_clr), .load_mins(load_mins),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .mag_on(mag_on), .beep(beep), .fsm_state(fsm_state)
`ifdef MICROWAVE_QUICK_START_EN
    , .add30(add30)
`endif
  );

  // Clock and reset defaults.
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0;
    clear = 1'b0; door_closed = 1'b1; tick_1hz = 1'b0; timer_zero = 1'b0;
  end

  // Driver tasks: inputs change on the falling edge, outputs are read on
  // the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input int d);
    key_valid = 1'b1; key_digit = 4'(d); step(); key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
    model_entry = 12'h000;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  // Entry model: digits as seconds/minutes positions; a key is a decimal
  // digit that appends on the right unless the rightmost digit could not
  // become a seconds-tens value.
  function automatic logic [11:0] model_key(input logic [11:0] cur, input int d);
    int mm, st, so;
    mm = int'(cur[11:8]); st = int'(cur[7:4]); so = int'(cur[3:0]);
    if (d > 9 || so > 5) return cur;
    mm = st; st = so; so = d;
    return {4'(mm), 4'(st), 4'(so)};
  endfunction

  function automatic logic [11:0] entry();
    return {load_mins, load_sec_tens, load_sec_ones};
  endfunction

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    model_entry = 12'h000;
    total_cnt++; if (fsm_state !== S_IDLE) $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); else pass_cnt++;
    total_cnt++; if ({timer_load, timer_en, timer_clr, mag_on, beep} !== 5'b0) $display("FAIL reset_outs got=%b exp=00000", {timer_load, timer_en, timer_clr, mag_on, beep}); else pass_cnt++;
    total_cnt++; if (entry() !== 12'h000) $display("FAIL reset_entry got=%h exp=000", entry()); else pass_cnt++;
  endtask

  task automatic test_cook_start();
    press(1); press(3); press(0);
    total_cnt++; if (entry() !== 12'h130) $display("FAIL start_entry got=%h exp=130", entry()); else pass_cnt++;
    door_closed = 1'b1;
    pulse_start();
    total_cnt++; if (timer_load !== 1'b1 || mag_on !== 1'b0) $display("FAIL start_load load=%b mag=%b exp 1 0", timer_load, mag_on); else pass_cnt++;
    step();
    total_cnt++; if (timer_load !== 1'b0 || mag_on !== 1'b1 || timer_en !== 1'b1) $display("FAIL start_cook load=%b mag=%b en=%b exp 0 1 1", timer_load, mag_on, timer_en); else pass_cnt++;
    total_cnt++; if (fsm_state !== S_COOK) $display("FAIL start_state got=%0d exp=%0d", fsm_state, S_COOK); else pass_cnt++;
  endtask

  task automatic test_door_pause();
    door_closed = 1'b0; step();
    total_cnt++; if (mag_on !== 1'b0 || timer_en !== 1'b0 || fsm_state !== S_PAUSE) $display("FAIL door_pause mag=%b en=%b st=%0d exp 0 0 %0d", mag_on, timer_en, fsm_state, S_PAUSE); else pass_cnt++;
    door_closed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (mag_on !== 1'b0) $display("FAIL door_hold mag=%b exp=0", mag_on); else pass_cnt++;
    end
    pulse_start();
    total_cnt++; if (mag_on !== 1'b1 || timer_load !== 1'b0) $display("FAIL door_resume mag=%b load=%b exp 1 0", mag_on, timer_load); else pass_cnt++;
    total_cnt++; if (entry() !== 12'h130) $display("FAIL door_entry got=%h exp=130", entry()); else pass_cnt++;
  endtask

  task automatic test_done_beep();
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    total_cnt++; if (mag_on !== 1'b0 || beep !== 1'b1 || fsm_state !== S_DONE) $display("FAIL done_enter mag=%b beep=%b st=%0d exp 0 1 %0d", mag_on, beep, fsm_state, S_DONE); else pass_cnt++;
    for (int t = 1; t <= BEEP; t++) begin
      repeat ($urandom_range(1, 4)) step();
      total_cnt++; if (beep !== 1'b1) $display("FAIL done_gap tick=%0d beep=%b exp=1", t, beep); else pass_cnt++;
      pulse_tick();
      if (t < BEEP) begin
        total_cnt++; if (beep !== 1'b1) $display("FAIL done_tick tick=%0d beep=%b exp=1", t, beep); else pass_cnt++;
      end else begin
        total_cnt++; if (beep !== 1'b0 || fsm_state !== S_IDLE) $display("FAIL done_end beep=%b st=%0d exp 0 %0d", beep, fsm_state, S_IDLE); else pass_cnt++;
        total_cnt++; if (entry() !== 12'h000) $display("FAIL done_entry got=%h exp=000", entry()); else pass_cnt++;
      end
    end
    model_entry = 12'h000;
  endtask

  task automatic test_keys();
    int seq[4] = '{4, 5, 9, 1};
    logic [11:0] got;
    logic [2:0]  exp_state;
    pulse_clear();
    press(7);
    total_cnt++; if (entry() !== 12'h007) $display("FAIL key_7 got=%h exp=007", entry()); else pass_cnt++;
    press(2);
    total_cnt++; if (entry() !== 12'h007 || fsm_state !== S_SET) $display("FAIL key_reject got=%h st=%0d exp 007 %0d", entry(), fsm_state, S_SET); else pass_cnt++;
    press(12);
    total_cnt++; if (entry() !== 12'h007) $display("FAIL key_12 got=%h exp=007", entry()); else pass_cnt++;
    pulse_clear();
    foreach (seq[i]) begin
      model_entry = model_key(model_entry, seq[i]);
      exp_q.push_back(model_entry);
      press(seq[i]);
      got = exp_q.pop_front();
      total_cnt++; if (entry() !== got) $display("FAIL key_seq key=%0d got=%h exp=%h", seq[i], entry(), got); else pass_cnt++;
    end
    for (int n = 0; n < 40; n++) begin
      int d;
      d = int'($urandom_range(0, 15));
      door_closed = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        exp_q.push_back(12'h000);
        pulse_clear();
      end else begin
        model_entry = model_key(model_entry, d);
        exp_q.push_back(model_entry);
        press(d);
      end
      got = exp_q.pop_front();
      exp_state = (got != 12'h000) ? S_SET : S_IDLE;
      total_cnt++; if (entry() !== got || fsm_state !== exp_state) $display("FAIL key_rand n=%0d got=%h/%0d exp=%h/%0d", n, entry(), fsm_state, got, exp_state); else pass_cnt++;
    end
    door_closed = 1'b1;
  endtask

  task automatic test_clear_start();
    pulse_clear(); press(2); pulse_start(); step();
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    total_cnt++; if (timer_clr !== 1'b1 || fsm_state !== S_IDLE) $display("FAIL clr_pulse clr=%b st=%0d exp 1 %0d", timer_clr, fsm_state, S_IDLE); else pass_cnt++;
    total_cnt++; if (mag_on !== 1'b0 || timer_en !== 1'b0 || entry() !== 12'h000) $display("FAIL clr_outs mag=%b en=%b entry=%h exp 0 0 000", mag_on, timer_en, entry()); else pass_cnt++;
    step();
    total_cnt++; if (timer_clr !== 1'b0) $display("FAIL clr_width clr=%b exp=0", timer_clr); else pass_cnt++;
    model_entry = 12'h000;
  endtask

  task automatic test_rst_midcook();
    press(4); pulse_start(); step();
    rst = 1'b1; step(); rst = 1'b0;
    total_cnt++; if ({timer_load, timer_en, timer_clr, mag_on, beep} !== 5'b0 || fsm_state !== S_IDLE) $display("FAIL rst_cook outs=%b st=%0d exp 00000 %0d", {timer_load, timer_en, timer_clr, mag_on, beep}, fsm_state, S_IDLE); else pass_cnt++;
    total_cnt++; if (entry() !== 12'h000) $display("FAIL rst_entry got=%h exp=000", entry()); else pass_cnt++;
    door_closed = 1'b1;
    pulse_start();
`ifdef MICROWAVE_QUICK_START_EN
    total_cnt++; if (timer_load !== 1'b1 || entry() !== 12'h030) $display("FAIL quick_load load=%b entry=%h exp 1 030", timer_load, entry()); else pass_cnt++;
    step();
    total_cnt++; if (mag_on !== 1'b1) $display("FAIL quick_cook mag=%b exp=1", mag_on); else pass_cnt++;
    pulse_start();
    total_cnt++; if (add30 !== 1'b1 || timer_load !== 1'b0) $display("FAIL quick_add30 add30=%b load=%b exp 1 0", add30, timer_load); else pass_cnt++;
    step();
    total_cnt++; if (add30 !== 1'b0 || mag_on !== 1'b1) $display("FAIL quick_add30_end add30=%b mag=%b exp 0 1", add30, mag_on); else pass_cnt++;
    pulse_clear();
`else
    total_cnt++; if (timer_load !== 1'b0 || fsm_state !== S_IDLE) $display("FAIL idle_start load=%b st=%0d exp 0 %0d", timer_load, fsm_state, S_IDLE); else pass_cnt++;
    step();
    total_cnt++; if (mag_on !== 1'b0) $display("FAIL idle_start_mag mag=%b exp=0", mag_on); else pass_cnt++;
`endif
    model_entry = 12'h000;
  endtask

  task automatic test_corners();
    press(5); pulse_start(); step();
    timer_zero = 1'b1; stop = 1'b1; step(); timer_zero = 1'b0; stop = 1'b0;
    total_cnt++; if (fsm_state !== S_PAUSE || mag_on !== 1'b0 || beep !== 1'b0) $display("FAIL stop_vs_zero st=%0d mag=%b beep=%b exp %0d 0 0", fsm_state, mag_on, beep, S_PAUSE); else pass_cnt++;
    press(3);
    total_cnt++; if (entry() !== 12'h005 || fsm_state !== S_PAUSE) $display("FAIL pause_key entry=%h st=%0d exp 005 %0d", entry(), fsm_state, S_PAUSE); else pass_cnt++;
    door_closed = 1'b0; pulse_start(); door_closed = 1'b1;
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    total_cnt++; if (fsm_state !== S_PAUSE || mag_on !== 1'b0) $display("FAIL pause_open_start st=%0d mag=%b exp %0d 0", fsm_state, mag_on, S_PAUSE); else pass_cnt++;
    pulse_stop();
    total_cnt++; if (timer_clr !== 1'b1 || fsm_state !== S_IDLE || entry() !== 12'h000) $display("FAIL pause_stop clr=%b st=%0d entry=%h exp 1 %0d 000", timer_clr, fsm_state, entry(), S_IDLE); else pass_cnt++;
    press(4); door_closed = 1'b0; pulse_start();
    total_cnt++; if (fsm_state !== S_SET || timer_load !== 1'b0) $display("FAIL set_open_start st=%0d load=%b exp %0d 0", fsm_state, timer_load, S_SET); else pass_cnt++;
    press(1); door_closed = 1'b1;
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    total_cnt++; if (entry() !== 12'h041 || fsm_state !== S_SET) $display("FAIL set_open_key entry=%h st=%0d exp 041 %0d", entry(), fsm_state, S_SET); else pass_cnt++;
    pulse_start(); step();
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    pulse_tick(); pulse_start();
    total_cnt++; if (beep !== 1'b1 || fsm_state !== S_DONE) $display("FAIL done_start beep=%b st=%0d exp 1 %0d", beep, fsm_state, S_DONE); else pass_cnt++;
    pulse_stop();
    total_cnt++; if (beep !== 1'b0 || fsm_state !== S_IDLE) $display("FAIL done_stop beep=%b st=%0d exp 0 %0d", beep, fsm_state, S_IDLE); else pass_cnt++;
    model_entry = 12'h000;
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int nk;
      pulse_clear();
      nk = int'($urandom_range(1, 3));
      for (int k = 0; k < nk; k++) begin
        int d;
        d = (k == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 15));
        model_entry = model_key(model_entry, d);
        press(d);
      end
      exp_q.push_back(model_entry);
      pulse_start();
      total_cnt++; if (timer_load !== 1'b1 || entry() !== exp_q[0]) $display("FAIL b2b_load it=%0d load=%b entry=%h exp 1 %h", it, timer_load, entry(), exp_q[0]); else pass_cnt++;
      void'(exp_q.pop_front());
      repeat ($urandom_range(1, 10)) begin
        step();
        total_cnt++; if (mag_on !== 1'b1 || timer_en !== 1'b1) $display("FAIL b2b_cook it=%0d mag=%b en=%b exp 1 1", it, mag_on, timer_en); else pass_cnt++;
      end
      timer_zero = 1'b1; step(); timer_zero = 1'b0;
      for (int t = 0; t < BEEP; t++) begin
        repeat ($urandom_range(0, 3)) step();
        pulse_tick();
      end
      total_cnt++; if (fsm_state !== S_IDLE || beep !== 1'b0 || entry() !== 12'h000) $display("FAIL b2b_end it=%0d st=%0d beep=%b entry=%h exp %0d 0 000", it, fsm_state, beep, entry(), S_IDLE); else pass_cnt++;
      model_entry = 12'h000;
    end
  endtask

  initial begin
    step();
    test_reset();
    test_cook_start();
    test_door_pause();
    test_done_beep();
    test_keys();
    test_clear_start();
    test_rst_midcook();
    test_corners();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
